// File: rtl/axiline_stream_loader.sv
// Stream front end for the Axiline accelerator: packs incoming words into weight-RAM rows,
// then buffers each sample's x vector and replays it in step with weight-RAM reads.
`ifndef INPUT_BITWIDTH
`define INPUT_BITWIDTH 8
`endif
`ifndef SIZE
`define SIZE 2
`endif
`ifndef NUMBER_UNIT
`define NUMBER_UNIT 2
`endif
`ifndef NUM_CYCLE
`define NUM_CYCLE 4
`endif
`ifndef LOG_NUM_CYCLE
`define LOG_NUM_CYCLE 2
`endif

// Handshake: a stream word transfers on a rising clk edge where in_valid and in_ready
// are both 1; in_data must be held while in_valid=1 and in_ready=0.
module axiline_stream_loader #(
  parameter int inputBitwidth = `INPUT_BITWIDTH,
  parameter int size          = `SIZE,
  parameter int numUnit       = `NUMBER_UNIT,
  parameter int numCycle      = `NUM_CYCLE,
  parameter int logNumCycle   = `LOG_NUM_CYCLE
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    cfg_go,
  input  logic                                    cfg_skip_w,
  input  logic [15:0]                             cfg_num_samples,
  input  logic [inputBitwidth-1:0]                in_data,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  output logic [inputBitwidth*size*numUnit-1:0]   data_in_w_init,
  output logic [logNumCycle-1:0]                  w_addr,
  output logic                                    w1_en,
  output logic                                    w2_en,
  output logic [inputBitwidth*size-1:0]           data_in_x,
  output logic                                    start,
  output logic                                    done,
  output logic                                    busy,
  output logic                                    job_done,
  output logic [1:0]                              state_dbg
);

  localparam int ROW_WORDS = size * numUnit;
  localparam int WCW = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;
  localparam int XCW = (size > 1) ? $clog2(size) : 1;
  localparam int TW  = logNumCycle + 1;
  localparam logic [WCW-1:0]         W_LAST = WCW'(ROW_WORDS - 1);
  localparam logic [WCW-1:0]         W_ONE  = WCW'(1);
  localparam logic [XCW-1:0]         X_LAST = XCW'(size - 1);
  localparam logic [XCW-1:0]         X_ONE  = XCW'(1);
  localparam logic [logNumCycle-1:0] C_LAST = logNumCycle'(numCycle - 1);
  localparam logic [logNumCycle-1:0] C_ONE  = logNumCycle'(1);
  localparam logic [TW-1:0]          T_END  = TW'(numCycle);
  localparam logic [TW-1:0]          T_ONE  = TW'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD_W = 2'd1,
    S_LOAD_X = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [WCW-1:0]                  wcnt;
  logic [XCW-1:0]                  xcnt;
  logic [logNumCycle-1:0]          row;
  logic [logNumCycle-1:0]          chunk;
  logic [logNumCycle-1:0]          addr_q;
  logic [TW-1:0]                   t;
  logic [15:0]                     samp;
  logic [ROW_WORDS*inputBitwidth-1:0] pack_w;
  logic [ROW_WORDS*inputBitwidth-1:0] row_word;
  logic [size*inputBitwidth-1:0]   xbuf [numCycle];
  logic                            w1_q;
  logic                            job_done_q;
  logic                            zero_pend;
  logic                            accept;
  logic                            go_ok;
  logic                            run_end;

  assign accept  = in_valid & in_ready;
  // A launch is refused while an empty-job pulse is pending or being shown.
  assign go_ok   = (state_q == S_IDLE) && cfg_go && !zero_pend && !job_done_q;
  assign run_end = (state_q == S_RUN) && (t == T_END);

  assign w1_en     = w1_q;
  assign job_done  = job_done_q;
  assign state_dbg = state_q;
  assign w_addr    = (state_q == S_RUN && !run_end) ? t[logNumCycle-1:0] : addr_q;

  always_comb begin
    row_word = pack_w;
    row_word[wcnt*inputBitwidth +: inputBitwidth] = in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    w2_en    = 1'b0;
    start    = 1'b0;
    done     = 1'b0;
    busy     = (state_q != S_IDLE);
    case (state_q)
      S_IDLE: begin
        if (go_ok) begin
          if (!cfg_skip_w)                   state_d = S_LOAD_W;
          else if (cfg_num_samples != 16'd0) state_d = S_LOAD_X;
        end
      end
      S_LOAD_W: begin
        in_ready = 1'b1;
        if (accept && wcnt == W_LAST && row == C_LAST)
          state_d = (samp != 16'd0) ? S_LOAD_X : S_IDLE;
      end
      S_LOAD_X: begin
        in_ready = 1'b1;
        if (accept && xcnt == X_LAST && chunk == C_LAST) state_d = S_RUN;
      end
      S_RUN: begin
        w2_en = !run_end;
        start = (t == '0);
        done  = run_end;
        if (run_end) state_d = (samp != 16'd1) ? S_LOAD_X : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt           <= '0;
      xcnt           <= '0;
      row            <= '0;
      chunk          <= '0;
      addr_q         <= '0;
      t              <= '0;
      samp           <= '0;
      pack_w         <= '0;
      data_in_w_init <= '0;
      data_in_x      <= '0;
      w1_q           <= 1'b0;
      job_done_q     <= 1'b0;
      zero_pend      <= 1'b0;
    end else begin
      w1_q       <= 1'b0;
      job_done_q <= 1'b0;
      zero_pend  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (zero_pend) job_done_q <= 1'b1;
          if (go_ok) begin
            samp      <= cfg_num_samples;
            wcnt      <= '0;
            xcnt      <= '0;
            row       <= '0;
            chunk     <= '0;
            t         <= '0;
            zero_pend <= cfg_skip_w && (cfg_num_samples == 16'd0);
          end
        end
        S_LOAD_W: begin
          if (accept) begin
            pack_w <= row_word;
            if (wcnt == W_LAST) begin
              // The finished row moves to the output register, freeing pack_w for the next row.
              wcnt           <= '0;
              data_in_w_init <= row_word;
              addr_q         <= row;
              w1_q           <= 1'b1;
              row            <= (row == C_LAST) ? '0 : row + C_ONE;
              if (row == C_LAST && samp == 16'd0) job_done_q <= 1'b1;
            end else begin
              wcnt <= wcnt + W_ONE;
            end
          end
        end
        S_LOAD_X: begin
          if (accept) begin
            if (xcnt == X_LAST) begin
              xcnt  <= '0;
              chunk <= (chunk == C_LAST) ? '0 : chunk + C_ONE;
            end else begin
              xcnt <= xcnt + X_ONE;
            end
          end
        end
        S_RUN: begin
          if (t == T_END) begin
            t    <= '0;
            samp <= samp - 16'd1;
            if (samp == 16'd1) job_done_q <= 1'b1;
          end else begin
            // x chunk lands one cycle after its address, matching the RAM read latency.
            data_in_x <= xbuf[t[logNumCycle-1:0]];
            addr_q    <= t[logNumCycle-1:0];
            t         <= t + T_ONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_LOAD_X && accept)
      xbuf[chunk][xcnt*inputBitwidth +: inputBitwidth] <= in_data;
  end

endmodule

// File: tb/tb_axiline_stream_loader.sv
// Self-checking bench for axiline_stream_loader: random streams scored against a
// word-to-row/chunk packing model and expected pulse timing.
module tb_axiline_stream_loader;

  localparam int IW = 8;
  localparam int SZ = 2;
  localparam int NU = 2;
  localparam int NC = 4;
  localparam int LNC = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              cfg_go = 1'b0;
  logic              cfg_skip_w = 1'b0;
  logic [15:0]       cfg_num_samples = '0;
  logic [IW-1:0]     in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [IW*SZ*NU-1:0] data_in_w_init;
  logic [LNC-1:0]    w_addr;
  logic              w1_en, w2_en, start, done, busy, job_done;
  logic [IW*SZ-1:0]  data_in_x;
  logic [1:0]        state_dbg;

  axiline_stream_loader #(
    .inputBitwidth(IW), .size(SZ), .numUnit(NU), .numCycle(NC), .logNumCycle(LNC)
  ) dut (
    .clk(clk), .rst(rst), .cfg_go(cfg_go), .cfg_skip_w(cfg_skip_w),
    .cfg_num_samples(cfg_num_samples), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .data_in_w_init(data_in_w_init), .w_addr(w_addr),
    .w1_en(w1_en), .w2_en(w2_en), .data_in_x(data_in_x), .start(start), .done(done),
    .busy(busy), .job_done(job_done), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Monitor: logs observable events with a cycle stamp, sampled on the falling edge.
  int cyc = 0;
  bit prev_w2 = 1'b0;
  int n_overlap, n_ready, n_busy;
  logic [31:0] w_data_q[$];
  logic [1:0]  w_addr_q[$];
  logic [1:0]  r_addr_q[$];
  logic [1:0]  done_addr_q[$];
  logic [15:0] x_q[$];
  logic [15:0] exp_q[$];
  int w1_cyc_q[$], acc_cyc_q[$], start_cyc_q[$], done_cyc_q[$], jd_cyc_q[$], go_cyc_q[$], w2_cyc_q[$];

  always @(negedge clk) begin
    cyc++;
    if (in_valid === 1'b1 && in_ready === 1'b1) acc_cyc_q.push_back(cyc);
    if (w1_en === 1'b1) begin
      w_data_q.push_back(data_in_w_init);
      w_addr_q.push_back(w_addr);
      w1_cyc_q.push_back(cyc);
    end
    if (w2_en === 1'b1) begin
      r_addr_q.push_back(w_addr);
      w2_cyc_q.push_back(cyc);
    end
    if (prev_w2) x_q.push_back(data_in_x);
    if (start === 1'b1) start_cyc_q.push_back(cyc);
    if (done === 1'b1) begin
      done_cyc_q.push_back(cyc);
      done_addr_q.push_back(w_addr);
    end
    if (job_done === 1'b1) jd_cyc_q.push_back(cyc);
    if (cfg_go === 1'b1) go_cyc_q.push_back(cyc);
    if (w1_en === 1'b1 && w2_en === 1'b1) n_overlap++;
    if (in_ready === 1'b1) n_ready++;
    if (busy === 1'b1) n_busy++;
    prev_w2 = (w2_en === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    w_data_q.delete(); w_addr_q.delete(); r_addr_q.delete(); done_addr_q.delete();
    x_q.delete(); exp_q.delete(); w1_cyc_q.delete(); acc_cyc_q.delete();
    start_cyc_q.delete(); done_cyc_q.delete(); jd_cyc_q.delete(); go_cyc_q.delete();
    w2_cyc_q.delete();
    n_overlap = 0; n_ready = 0; n_busy = 0;
  endtask

  task automatic pulse_go(input bit skip, input logic [15:0] n);
    cfg_go = 1'b1; cfg_skip_w = skip; cfg_num_samples = n;
    step();
    cfg_go = 1'b0;
  endtask

  // Offers words in order; with toggle set, in_valid is high only every other cycle.
  task automatic stream(input logic [7:0] words[$], input bit toggle);
    int i = 0;
    int n = 0;
    bit ph = 1'b1;
    logic acc;
    while (i < words.size() && n < 400) begin
      in_data = words[i];
      in_valid = toggle ? ph : 1'b1;
      ph = !ph;
      @(negedge clk);
      acc = in_valid && in_ready;
      step();
      if (acc) i++;
      n++;
    end
    in_valid = 1'b0;
    in_data = '0;
    if (i < words.size()) begin
      total++; bad++;
      $display("FAIL stream_timeout: accepted %0d words, required %0d", i, words.size());
    end
  endtask

  task automatic wait_jd(input int want, input int budget);
    int n = 0;
    while (jd_cyc_q.size() < want && n < budget) begin
      step();
      n++;
    end
    total++;
    if (jd_cyc_q.size() < want) begin
      bad++;
      $display("FAIL job_done_timeout: got %0d pulses, required %0d", jd_cyc_q.size(), want);
    end
  endtask

  // Reference packing: chunk c of a sample is word 2c | word 2c+1 << 8.
  function automatic logic [15:0] x_chunk(input logic [7:0] w[$], input int base, input int c);
    return {8'h00, w[base + 2*c]} | ({8'h00, w[base + 2*c + 1]} << 8);
  endfunction

  task automatic check_run_pass(input string tag, input logic [7:0] xw[$], input int pass,
                                input int last_acc);
    int s;
    for (int c = 0; c < NC; c++) exp_q.push_back(x_chunk(xw, pass*SZ*NC, c));
    total++;
    if (start_cyc_q.size() <= pass) begin
      bad++; $display("FAIL %s_start_missing: got %0d starts", tag, start_cyc_q.size());
      return;
    end
    s = start_cyc_q[pass];
    total++;
    if (s !== last_acc + 1) begin
      bad++; $display("FAIL %s_start_cycle: got %0d want %0d", tag, s, last_acc + 1);
    end
    for (int k = 0; k < NC; k++) begin
      total++;
      if (w2_cyc_q.size() <= pass*NC + k || w2_cyc_q[pass*NC+k] !== s + k
          || r_addr_q[pass*NC+k] !== 2'(k)) begin
        bad++; $display("FAIL %s_read_t%0d: w2 events %0d, want addr %0d at cycle %0d",
                        tag, k, w2_cyc_q.size(), k, s + k);
      end
    end
    for (int k = 0; k < NC; k++) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      total++;
      if (x_q.size() <= pass*NC + k || x_q[pass*NC+k] !== e) begin
        bad++; $display("FAIL %s_x_t%0d: got %h want %h", tag, k + 1,
                        (x_q.size() > pass*NC + k) ? x_q[pass*NC+k] : 16'hxxxx, e);
      end
    end
    total++;
    if (done_cyc_q.size() <= pass || done_cyc_q[pass] !== s + NC || done_addr_q[pass] !== 2'(NC-1)) begin
      bad++; $display("FAIL %s_done: dones %0d, want one at cycle %0d with w_addr %0d",
                      tag, done_cyc_q.size(), s + NC, NC - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    total++; if ({w1_en, w2_en, start, done, job_done} !== 5'b0) begin
      bad++; $display("FAIL reset_pulses: got %b want 00000", {w1_en, w2_en, start, done, job_done});
    end
    total++; if (w_addr !== '0) begin bad++; $display("FAIL reset_w_addr: got %h want 0", w_addr); end
    total++; if (data_in_w_init !== '0) begin bad++; $display("FAIL reset_w_init: got %h want 0", data_in_w_init); end
    total++; if (data_in_x !== '0) begin bad++; $display("FAIL reset_x: got %h want 0", data_in_x); end
    step();
  endtask

  logic [7:0] ww[$];
  logic [7:0] xw[$];

  task automatic test_weight_load();
    clear_mon();
    pulse_go(1'b0, 16'd1);
    @(negedge clk);
    total++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      bad++; $display("FAIL wload_entry: busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    step();
    ww.delete();
    for (int i = 1; i <= 16; i++) ww.push_back(8'(i));
    stream(ww, 1'b0);
    step();
    total++; if (w_data_q.size() !== NC) begin
      bad++; $display("FAIL wload_rows: got %0d writes want %0d", w_data_q.size(), NC);
    end
    for (int r = 0; r < NC && r < w_data_q.size(); r++) begin
      logic [31:0] e;
      e = '0;
      for (int k = 0; k < SZ*NU; k++) e |= 32'(ww[r*SZ*NU + k]) << (8*k);
      total++;
      if (w_data_q[r] !== e || w_addr_q[r] !== 2'(r) || w1_cyc_q[r] !== acc_cyc_q[r*SZ*NU + 3] + 1) begin
        bad++; $display("FAIL wload_row%0d: got %h@%0d cyc %0d want %h@%0d cyc %0d", r, w_data_q[r],
                        w_addr_q[r], w1_cyc_q[r], e, r, acc_cyc_q[r*SZ*NU + 3] + 1);
      end
    end
  endtask

  task automatic test_run();
    clear_mon();
    xw.delete();
    for (int i = 0; i < 8; i++) xw.push_back(8'hA0 + 8'(i));
    stream(xw, 1'b0);
    wait_jd(1, 30);
    check_run_pass("run", xw, 0, acc_cyc_q[acc_cyc_q.size()-1]);
    total++; if (jd_cyc_q.size() !== 1 || done_cyc_q.size() < 1 || jd_cyc_q[0] !== done_cyc_q[0] + 1) begin
      bad++; $display("FAIL run_job_done: got %0d pulses, want 1 right after done", jd_cyc_q.size());
    end
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++; $display("FAIL run_idle: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
    step();
  endtask

  task automatic test_back_to_back();
    clear_mon();
    pulse_go(1'b1, 16'd2);
    xw.delete();
    for (int i = 0; i < 2*SZ*NC; i++) xw.push_back(8'($urandom_range(0, 255)));
    stream(xw, 1'b1);
    wait_jd(1, 40);
    repeat (5) step();
    total++; if (acc_cyc_q.size() !== 2*SZ*NC) begin
      bad++; $display("FAIL bp_accepts: got %0d want %0d", acc_cyc_q.size(), 2*SZ*NC);
    end
    check_run_pass("bp_p0", xw, 0, acc_cyc_q[SZ*NC-1]);
    check_run_pass("bp_p1", xw, 1, acc_cyc_q[2*SZ*NC-1]);
    total++; if (start_cyc_q.size() !== 2 || done_cyc_q.size() !== 2 || jd_cyc_q.size() !== 1) begin
      bad++; $display("FAIL bp_counts: start=%0d done=%0d job_done=%0d want 2 2 1",
                      start_cyc_q.size(), done_cyc_q.size(), jd_cyc_q.size());
    end
    total++; if (w1_cyc_q.size() !== 0 || n_overlap !== 0) begin
      bad++; $display("FAIL bp_no_write: w1 pulses=%0d overlaps=%0d want 0 0", w1_cyc_q.size(), n_overlap);
    end
  endtask

  task automatic test_abort();
    clear_mon();
    pulse_go(1'b1, 16'd1);
    xw.delete();
    for (int i = 0; i < 3; i++) xw.push_back(8'($urandom_range(0, 255)));
    stream(xw, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0 || job_done !== 1'b0) begin
      bad++; $display("FAIL abort_state: busy=%b in_ready=%b done=%b job_done=%b want 0 0 0 0",
                      busy, in_ready, done, job_done);
    end
    step(); step();
    rst = 1'b1;
    repeat (6) step();
    total++; if (done_cyc_q.size() !== 0 || jd_cyc_q.size() !== 0 || start_cyc_q.size() !== 0) begin
      bad++; $display("FAIL abort_pulses: start=%0d done=%0d job_done=%0d want 0 0 0",
                      start_cyc_q.size(), done_cyc_q.size(), jd_cyc_q.size());
    end
  endtask

  task automatic test_degenerate();
    clear_mon();
    cfg_go = 1'b1; cfg_skip_w = 1'b1; cfg_num_samples = 16'd0;
    repeat (3) step();
    cfg_go = 1'b0;
    repeat (6) step();
    total++; if (jd_cyc_q.size() !== 1 || go_cyc_q.size() < 1 || jd_cyc_q[0] !== go_cyc_q[0] + 2) begin
      bad++; $display("FAIL empty_job_done: got %0d pulses first at %0d, want 1 at %0d",
                      jd_cyc_q.size(), (jd_cyc_q.size() > 0) ? jd_cyc_q[0] : -1,
                      (go_cyc_q.size() > 0) ? go_cyc_q[0] + 2 : -1);
    end
    total++; if (n_ready !== 0 || n_busy !== 0) begin
      bad++; $display("FAIL empty_quiet: in_ready cycles=%0d busy cycles=%0d want 0 0", n_ready, n_busy);
    end
    clear_mon();
    pulse_go(1'b1, 16'd1);
    xw.delete();
    for (int i = 0; i < SZ*NC; i++) xw.push_back(8'($urandom_range(0, 255)));
    stream(xw[0:1], 1'b0);
    pulse_go(1'b0, 16'd5);
    stream(xw[2:SZ*NC-1], 1'b0);
    wait_jd(1, 30);
    repeat (8) step();
    total++; if (start_cyc_q.size() !== 1 || jd_cyc_q.size() !== 1 || w1_cyc_q.size() !== 0 || busy !== 1'b0) begin
      bad++; $display("FAIL busy_go_ignored: start=%0d job_done=%0d w1=%0d busy=%b want 1 1 0 0",
                      start_cyc_q.size(), jd_cyc_q.size(), w1_cyc_q.size(), busy);
    end
  endtask

  initial begin
    test_reset();
    test_weight_load();
    test_run();
    test_back_to_back();
    test_abort();
    test_degenerate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
